// File: rtl/ocp_pkg.sv
// Shared encodings and helpers for the OCP burst master.
// MCmd/SResp codes, FSM state enum, bytes-per-beat helper.
package ocp_pkg;

    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WR_CMD,
        S_WR_RESP,
        S_RD_CMD,
        S_RD_RESP,
        S_RETURN
    } state_e;

    function automatic int bytes_per_beat(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ocp_burst_buf.sv
// Burst beat store shared by the write and read paths.
// Ports: clk, rst (async, active-low), flush, wr_en/wr_idx/wr_data,
//        rd_idx/rd_data (combinational read).
module ocp_burst_buf #(
    parameter int DATAWIDTH = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_BURST)-1:0] wr_idx,
    input  logic [DATAWIDTH-1:0]         wr_data,
    input  logic [$clog2(MAX_BURST)-1:0] rd_idx,
    output logic [DATAWIDTH-1:0]         rd_data
);

    logic [DATAWIDTH-1:0] mem [MAX_BURST];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_BURST; i++)
                mem[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_BURST; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ocp_burst_master.sv
// OCP burst master: buffers CPU write/read bursts onto the OCP bus.
// Ports: CPU side mem*, OCP side M*/S*, request, Err; rst async active-low.
// Optional OCP_RESP_TIMEOUT_EN adds a TIMEOUT-cycle bus watchdog.
module ocp_burst_master
    import ocp_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int MAX_BURST    = 8,
    parameter int LENW         = $clog2(MAX_BURST) + 1
`ifdef OCP_RESP_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memWrite,
    input  logic                    memRead,
    input  logic [ADDRESSWIDTH-1:0] memAddr,
    input  logic [LENW-1:0]         memLen,
    input  logic [DATAWIDTH-1:0]    memDataOut,
    output logic [DATAWIDTH-1:0]    memDataIn,
    output logic                    memDataValid,
    output logic                    memDataLast,
    output logic                    memReady,
    output logic                    Err,
    output logic [2:0]              MCmd,
    output logic [ADDRESSWIDTH-1:0] MAddr,
    output logic [LENW-1:0]         MBurstLength,
    output logic [DATAWIDTH-1:0]    MData,
    output logic                    MDataValid,
    output logic                    MDataLast,
    output logic                    MRespAccept,
    input  logic                    SCmdAccept,
    input  logic [1:0]              SResp,
    input  logic [DATAWIDTH-1:0]    SData,
    input  logic                    SRespLast,
    output logic                    request
);

    localparam int IW = $clog2(MAX_BURST);
    localparam logic [ADDRESSWIDTH-1:0] BPB =
        ADDRESSWIDTH'(bytes_per_beat(DATAWIDTH));
    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
    localparam logic [LENW-1:0] LEN_MAX = LENW'(MAX_BURST);

    state_e state, state_n;

    logic [ADDRESSWIDTH-1:0] base, base_n;
    logic [LENW-1:0] len, len_n;
    logic [LENW-1:0] idx, idx_n, idx_inc;
    logic [LENW-1:0] eff_len;

    logic [2:0]              mcmd_n;
    logic [ADDRESSWIDTH-1:0] maddr_n;
    logic [LENW-1:0]         mblen_n;
    logic [DATAWIDTH-1:0]    mdata_n;
    logic                    mdv_n, mdl_n, mra_n;
    logic [DATAWIDTH-1:0]    rdata_n;
    logic                    rdv_n, rdl_n, err_n;

    logic                 resp_dva, resp_err;
    logic                 buf_we, buf_flush;
    logic [IW-1:0]        buf_widx, buf_ridx;
    logic [DATAWIDTH-1:0] buf_wdata, buf_rdata;

    function automatic logic [ADDRESSWIDTH-1:0] beat_addr(
        input logic [ADDRESSWIDTH-1:0] b,
        input logic [LENW-1:0]         i
    );
        return b + ADDRESSWIDTH'(i) * BPB;
    endfunction

    ocp_burst_buf #(
        .DATAWIDTH(DATAWIDTH),
        .MAX_BURST(MAX_BURST)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .flush  (buf_flush),
        .wr_en  (buf_we),
        .wr_idx (buf_widx),
        .wr_data(buf_wdata),
        .rd_idx (buf_ridx),
        .rd_data(buf_rdata)
    );

    assign idx_inc = idx + LEN_ONE;

    always_comb begin
        unique case (1'b1)
            (memLen == '0):     eff_len = LEN_ONE;
            (memLen > LEN_MAX): eff_len = LEN_MAX;
            default:            eff_len = memLen;
        endcase
    end

    // Reserved code 10 is handled as an error.
    always_comb begin
        resp_dva = 1'b0;
        resp_err = 1'b0;
        case (SResp)
            SRESP_NULL: ;
            SRESP_DVA:  resp_dva = 1'b1;
            SRESP_ERR:  resp_err = 1'b1;
            default:    resp_err = 1'b1;
        endcase
    end

`ifdef OCP_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_busy, tmo_kick, tmo_hit;

    assign tmo_busy = state inside
        {S_WR_CMD, S_WR_RESP, S_RD_CMD, S_RD_RESP};
    assign tmo_kick = SCmdAccept || (SResp != SRESP_NULL);
    assign tmo_hit  = tmo_busy && !tmo_kick &&
                      (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (!tmo_busy || tmo_kick)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end
`endif

    always_comb begin
        state_n   = state;
        base_n    = base;
        len_n     = len;
        idx_n     = idx;
        mcmd_n    = MCmd;
        maddr_n   = MAddr;
        mblen_n   = MBurstLength;
        mdata_n   = MData;
        mdv_n     = MDataValid;
        mdl_n     = MDataLast;
        mra_n     = MRespAccept;
        rdata_n   = memDataIn;
        rdv_n     = memDataValid;
        rdl_n     = memDataLast;
        err_n     = 1'b0;
        buf_we    = 1'b0;
        buf_flush = 1'b0;
        buf_widx  = idx[IW-1:0];
        buf_wdata = SData;
        buf_ridx  = idx_inc[IW-1:0];

        case (state)
            S_IDLE: begin
                idx_n = '0;
                if (memWrite) begin
                    base_n    = memAddr;
                    len_n     = eff_len;
                    buf_we    = 1'b1;
                    buf_widx  = '0;
                    buf_wdata = memDataOut;
                    if (eff_len == LEN_ONE) begin
                        // Single beat: bypass the buffer for 1-cycle issue.
                        state_n = S_WR_CMD;
                        mcmd_n  = MCMD_WR;
                        maddr_n = memAddr;
                        mblen_n = eff_len;
                        mdata_n = memDataOut;
                        mdv_n   = 1'b1;
                        mdl_n   = 1'b1;
                    end else begin
                        state_n = S_COLLECT;
                        idx_n   = LEN_ONE;
                    end
                end else if (memRead) begin
                    base_n  = memAddr;
                    len_n   = eff_len;
                    state_n = S_RD_CMD;
                    mcmd_n  = MCMD_RD;
                    maddr_n = memAddr;
                    mblen_n = eff_len;
                end
            end

            S_COLLECT: begin
                buf_ridx = '0;
                if (memWrite) begin
                    buf_we    = 1'b1;
                    buf_wdata = memDataOut;
                    idx_n     = idx_inc;
                    if (idx_inc == len) begin
                        state_n = S_WR_CMD;
                        idx_n   = '0;
                        mcmd_n  = MCMD_WR;
                        maddr_n = base;
                        mblen_n = len;
                        mdata_n = buf_rdata;
                        mdv_n   = 1'b1;
                        mdl_n   = 1'b0;
                    end
                end
            end

            S_WR_CMD: begin
                if (SCmdAccept) begin
                    if (idx_inc == len) begin
                        state_n = S_WR_RESP;
                        mcmd_n  = MCMD_IDLE;
                        mblen_n = '0;
                        mdata_n = '0;
                        mdv_n   = 1'b0;
                        mdl_n   = 1'b0;
                        mra_n   = 1'b1;
                    end else begin
                        idx_n   = idx_inc;
                        maddr_n = beat_addr(base, idx_inc);
                        mdata_n = buf_rdata;
                        mdl_n   = (idx_inc == len - LEN_ONE);
                    end
                end
            end

            S_WR_RESP: begin
                if (resp_dva || resp_err) begin
                    state_n = S_IDLE;
                    mra_n   = 1'b0;
                    err_n   = resp_err;
                end
            end

            S_RD_CMD: begin
                if (SCmdAccept) begin
                    state_n = S_RD_RESP;
                    mcmd_n  = MCMD_IDLE;
                    mblen_n = '0;
                    mra_n   = 1'b1;
                end
            end

            S_RD_RESP: begin
                buf_ridx = '0;
                if (resp_err) begin
                    buf_flush = 1'b1;
                    err_n     = 1'b1;
                    state_n   = S_IDLE;
                    mra_n     = 1'b0;
                    idx_n     = '0;
                end else if (resp_dva) begin
                    buf_we = 1'b1;
                    idx_n  = idx_inc;
                    if (SRespLast || idx_inc == len) begin
                        // Replay length becomes the beats actually received.
                        state_n = S_RETURN;
                        mra_n   = 1'b0;
                        len_n   = idx_inc;
                        idx_n   = '0;
                        rdv_n   = 1'b1;
                        rdata_n = (idx == '0) ? SData : buf_rdata;
                        rdl_n   = (idx_inc == LEN_ONE);
                    end
                end
            end

            S_RETURN: begin
                if (idx_inc == len) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    rdv_n   = 1'b0;
                    rdl_n   = 1'b0;
                    rdata_n = '0;
                end else begin
                    idx_n   = idx_inc;
                    rdata_n = buf_rdata;
                    rdl_n   = (idx_inc == len - LEN_ONE);
                end
            end

            default: state_n = S_IDLE;
        endcase

`ifdef OCP_RESP_TIMEOUT_EN
        if (tmo_hit) begin
            state_n   = S_IDLE;
            err_n     = 1'b1;
            buf_flush = 1'b1;
            buf_we    = 1'b0;
            idx_n     = '0;
            mcmd_n    = MCMD_IDLE;
            mblen_n   = '0;
            mdata_n   = '0;
            mdv_n     = 1'b0;
            mdl_n     = 1'b0;
            mra_n     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            base         <= '0;
            len          <= '0;
            idx          <= '0;
            MCmd         <= MCMD_IDLE;
            MAddr        <= '0;
            MBurstLength <= '0;
            MData        <= '0;
            MDataValid   <= 1'b0;
            MDataLast    <= 1'b0;
            MRespAccept  <= 1'b0;
            memDataIn    <= '0;
            memDataValid <= 1'b0;
            memDataLast  <= 1'b0;
            memReady     <= 1'b1;
            request      <= 1'b0;
            Err          <= 1'b0;
        end else begin
            state        <= state_n;
            base         <= base_n;
            len          <= len_n;
            idx          <= idx_n;
            MCmd         <= mcmd_n;
            MAddr        <= maddr_n;
            MBurstLength <= mblen_n;
            MData        <= mdata_n;
            MDataValid   <= mdv_n;
            MDataLast    <= mdl_n;
            MRespAccept  <= mra_n;
            memDataIn    <= rdata_n;
            memDataValid <= rdv_n;
            memDataLast  <= rdl_n;
            memReady     <= (state_n == S_IDLE);
            request      <= (state_n != S_IDLE);
            Err          <= err_n;
        end
    end

endmodule

// File: tb/tb_ocp_burst_master.sv
// Directed bench for ocp_burst_master (32-bit data, 8-beat bursts).
// Checks use immediate assertions against hand-computed values.
module tb_ocp_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memWrite = 1'b0;
    logic        memRead = 1'b0;
    logic [31:0] memAddr = '0;
    logic [3:0]  memLen = '0;
    logic [31:0] memDataOut = '0;
    logic [31:0] memDataIn;
    logic        memDataValid;
    logic        memDataLast;
    logic        memReady;
    logic        Err;
    logic [2:0]  MCmd;
    logic [31:0] MAddr;
    logic [3:0]  MBurstLength;
    logic [31:0] MData;
    logic        MDataValid;
    logic        MDataLast;
    logic        MRespAccept;
    logic        SCmdAccept = 1'b0;
    logic [1:0]  SResp = 2'b00;
    logic [31:0] SData = '0;
    logic        SRespLast = 1'b0;
    logic        request;

    int total = 0;
    int bad = 0;

    ocp_burst_master #(
        .DATAWIDTH(32),
        .ADDRESSWIDTH(32),
        .MAX_BURST(8),
        .LENW(4)
`ifdef OCP_RESP_TIMEOUT_EN
        , .TIMEOUT(15)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .memWrite(memWrite), .memRead(memRead),
        .memAddr(memAddr), .memLen(memLen),
        .memDataOut(memDataOut), .memDataIn(memDataIn),
        .memDataValid(memDataValid), .memDataLast(memDataLast),
        .memReady(memReady), .Err(Err),
        .MCmd(MCmd), .MAddr(MAddr),
        .MBurstLength(MBurstLength), .MData(MData),
        .MDataValid(MDataValid), .MDataLast(MDataLast),
        .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
        .SResp(SResp), .SData(SData),
        .SRespLast(SRespLast), .request(request)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // reset state
        chk("rst_ready", memReady, 1);
        chk("rst_mcmd", MCmd, 0);
        chk("rst_req", request, 0);
        chk("rst_err", Err, 0);
        chk("rst_mdv", MDataValid, 0);
        chk("rst_rdv", memDataValid, 0);

        // single write
        memWrite = 1; memAddr = 32'h100; memLen = 1;
        memDataOut = 32'hA5; SCmdAccept = 1;
        tick();
        memWrite = 0;
        chk("w1_mcmd", MCmd, 3'b001);
        chk("w1_addr", MAddr, 32'h100);
        chk("w1_data", MData, 32'hA5);
        chk("w1_last", MDataLast, 1);
        chk("w1_blen", MBurstLength, 1);
        chk("w1_ready", memReady, 0);
        chk("w1_req", request, 1);
        tick();
        chk("w1_idle", MCmd, 0);
        chk("w1_racc", MRespAccept, 1);
        SResp = 2'b01;
        tick();
        SResp = 2'b00;
        chk("w1_done", memReady, 1);
        chk("w1_noerr", Err, 0);
        chk("w1_noreq", request, 0);

        // 4-beat write with a collect stall and accept stall
        SCmdAccept = 0;
        memWrite = 1; memAddr = 32'h1000; memLen = 4;
        memDataOut = 32'h11;
        tick();
        chk("w4_col_mcmd", MCmd, 0);
        chk("w4_col_rdy", memReady, 0);
        memDataOut = 32'h22;
        tick();
        memWrite = 0; memDataOut = 32'hDEAD;
        tick();
        memWrite = 1; memDataOut = 32'h33;
        tick();
        memDataOut = 32'h44;
        tick();
        memWrite = 0;
        chk("w4_b0_cmd", MCmd, 3'b001);
        chk("w4_b0_addr", MAddr, 32'h1000);
        chk("w4_b0_data", MData, 32'h11);
        chk("w4_b0_last", MDataLast, 0);
        chk("w4_blen", MBurstLength, 4);
        SCmdAccept = 1;
        tick();
        chk("w4_b1_addr", MAddr, 32'h1004);
        chk("w4_b1_data", MData, 32'h22);
        tick();
        chk("w4_b2_addr", MAddr, 32'h1008);
        chk("w4_b2_data", MData, 32'h33);
        SCmdAccept = 0;
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("w4_hold_addr", MAddr, 32'h1008);
            chk("w4_hold_data", MData, 32'h33);
            chk("w4_hold_last", MDataLast, 0);
        end
        SCmdAccept = 1;
        tick();
        chk("w4_b3_addr", MAddr, 32'h100C);
        chk("w4_b3_data", MData, 32'h44);
        chk("w4_b3_last", MDataLast, 1);
        tick();
        SCmdAccept = 0;
        chk("w4_end_cmd", MCmd, 0);
        chk("w4_end_dv", MDataValid, 0);
        SResp = 2'b01;
        tick();
        SResp = 2'b00;
        chk("w4_ready", memReady, 1);

        // 8-beat read
        memRead = 1; memAddr = 32'h2000; memLen = 8;
        tick();
        memRead = 0;
        chk("r8_cmd", MCmd, 3'b010);
        chk("r8_addr", MAddr, 32'h2000);
        chk("r8_blen", MBurstLength, 8);
        SCmdAccept = 1;
        tick();
        SCmdAccept = 0;
        chk("r8_resp_cmd", MCmd, 0);
        chk("r8_racc", MRespAccept, 1);
        for (int i = 0; i < 8; i++) begin
            SResp = 2'b01; SData = 32'(i); SRespLast = (i == 7);
            tick();
            if (i == 0) chk("r8_novalid", memDataValid, 0);
        end
        SResp = 2'b00; SRespLast = 0;
        for (int j = 0; j < 8; j++) begin
            chk("r8_valid", memDataValid, 1);
            chk("r8_data", memDataIn, 64'(j));
            chk("r8_last", memDataLast, (j == 7));
            tick();
        end
        chk("r8_end_valid", memDataValid, 0);
        chk("r8_ready", memReady, 1);

        // read aborted by ERR on beat 2
        memRead = 1; memAddr = 32'h3000; memLen = 4;
        tick();
        memRead = 0; SCmdAccept = 1;
        tick();
        SCmdAccept = 0;
        SResp = 2'b01; SData = 32'hAA;
        tick();
        SData = 32'hBB;
        tick();
        SResp = 2'b11;
        tick();
        SResp = 2'b00;
        chk("rerr_err", Err, 1);
        chk("rerr_valid", memDataValid, 0);
        chk("rerr_ready", memReady, 1);
        chk("rerr_req", request, 0);
        tick();
        chk("rerr_pulse", Err, 0);
        chk("rerr_valid2", memDataValid, 0);

        // memLen=0 behaves as 1; reserved SResp 10 is an error
        memWrite = 1; memAddr = 32'h40; memLen = 0;
        memDataOut = 32'h77; SCmdAccept = 1;
        tick();
        memWrite = 0;
        chk("l0_cmd", MCmd, 3'b001);
        chk("l0_blen", MBurstLength, 1);
        chk("l0_last", MDataLast, 1);
        tick();
        SCmdAccept = 0;
        SResp = 2'b10;
        tick();
        SResp = 2'b00;
        chk("l0_err", Err, 1);
        chk("l0_ready", memReady, 1);
        tick();
        chk("l0_pulse", Err, 0);

        // memLen above MAX_BURST clamps to 8; ends on count
        memRead = 1; memAddr = 32'h500; memLen = 11;
        tick();
        memRead = 0;
        chk("lc_blen", MBurstLength, 8);
        SCmdAccept = 1;
        tick();
        SCmdAccept = 0;
        for (int i = 0; i < 8; i++) begin
            SResp = 2'b01; SData = 32'h100 + 32'(i);
            tick();
        end
        SResp = 2'b00;
        for (int j = 0; j < 8; j++) begin
            chk("lc_valid", memDataValid, 1);
            chk("lc_data", memDataIn, 64'h100 + 64'(j));
            chk("lc_last", memDataLast, (j == 7));
            tick();
        end
        chk("lc_done", memDataValid, 0);

        // early SRespLast shortens the replay
        memRead = 1; memAddr = 32'h700; memLen = 4;
        tick();
        memRead = 0; SCmdAccept = 1;
        tick();
        SCmdAccept = 0;
        SResp = 2'b01; SData = 32'h55;
        tick();
        SData = 32'h66; SRespLast = 1;
        tick();
        SResp = 2'b00; SRespLast = 0;
        chk("el_d0", memDataIn, 32'h55);
        chk("el_l0", memDataLast, 0);
        tick();
        chk("el_d1", memDataIn, 32'h66);
        chk("el_l1", memDataLast, 1);
        tick();
        chk("el_end", memDataValid, 0);
        chk("el_ready", memReady, 1);

        // address wrap
        memWrite = 1; memAddr = 32'hFFFF_FFFC; memLen = 2;
        memDataOut = 32'h1;
        tick();
        memDataOut = 32'h2;
        tick();
        memWrite = 0;
        chk("wr_a0", MAddr, 32'hFFFF_FFFC);
        SCmdAccept = 1;
        tick();
        chk("wr_a1", MAddr, 32'h0);
        chk("wr_d1", MData, 32'h2);
        chk("wr_l1", MDataLast, 1);
        tick();
        SCmdAccept = 0;
        SResp = 2'b01;
        tick();
        SResp = 2'b00;
        chk("wr_ready", memReady, 1);

        // async reset during WR_CMD
        memWrite = 1; memAddr = 32'h800; memLen = 1;
        memDataOut = 32'h99;
        tick();
        memWrite = 0;
        chk("ar_pre", MCmd, 3'b001);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mcmd", MCmd, 0);
        chk("ar_mdv", MDataValid, 0);
        chk("ar_ready", memReady, 1);
        chk("ar_req", request, 0);
        chk("ar_err", Err, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("ar_idle", MCmd, 0);
        chk("ar_noerr", Err, 0);

`ifdef OCP_RESP_TIMEOUT_EN
        begin
            int n;
            n = 0;
            memRead = 1; memAddr = 32'h600; memLen = 2;
            tick();
            memRead = 0;
            while (n < 40 && !Err) begin
                tick();
                n++;
            end
            chk("tmo_cycles", 64'(n), 64'd15);
            chk("tmo_mcmd", MCmd, 0);
            chk("tmo_ready", memReady, 1);
            tick();
            chk("tmo_pulse", Err, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
